ctrl_fila: RTL and testbench



---
 rtl/fila_pkg.sv | 19 +
 rtl/ctrl_fila_edge_sync.sv | 30 +++
 rtl/ctrl_fila.sv | 165 ++++++++++++++++
 tb/tb_ctrl_fila.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared types and defaults for the queue controller (ctrl_fila) and its
// button synchronizers.
package fila_pkg;

    localparam int FILA_DATA_W  = 8;
    localparam int FILA_DEPTH   = 8;
    localparam int FILA_DEQ_LAT = 2;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ENQ,
        ENQ_WAIT,
        DEQ,
        DEQ_WAIT,
        CAPTURE
    } ctrl_state_t;

endpackage

// File: rtl/ctrl_fila_edge_sync.sv
// Button conditioner: SYNC_STAGES-flop synchronizer followed by a registered
// rising-edge detector, giving one pulse per press three edges after the rise.
module edge_sync
    import fila_pkg::*;
(
    input  logic clk_10KHz,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   pulse_reg;

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], async_in};
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/ctrl_fila.sv
// Button-driven controller for the 8-entry queue: legality checks, enqueue /
// two-cycle dequeue sequencing, head capture. Optional counters: CTRL_FILA_STATS_EN.
module ctrl_fila
    import fila_pkg::*;
#(
    parameter int DATA_W  = FILA_DATA_W,
    parameter int DEPTH   = FILA_DEPTH,
    parameter int DEQ_LAT = FILA_DEQ_LAT
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              btn_enq,
    input  logic              btn_deq,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [7:0]        len_in,
    input  logic [DATA_W-1:0] data_q_in,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_to_q,
    output logic [DATA_W-1:0] shown_data,
    output logic              shown_valid,
    output logic              full,
    output logic              empty,
    output logic              err_out
`ifdef CTRL_FILA_STATS_EN
    ,
    output logic [7:0]        enq_count,
    output logic [7:0]        deq_count,
    output logic [7:0]        rej_count
`endif
);

    localparam int         CNT_W    = (DEQ_LAT > 1) ? $clog2(DEQ_LAT) : 1;
    localparam logic [7:0] DEPTH_L  = 8'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEQ_LAT - 1);

    // bit 0 = enqueue button, bit 1 = dequeue button
    logic [1:0] btn_raw;
    logic [1:0] btn_evt;
    logic       enq_evt;
    logic       deq_evt;

    assign btn_raw = {btn_deq, btn_enq};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            edge_sync u_sync (
                .clk_10KHz (clk_10KHz),
                .reset     (reset),
                .async_in  (btn_raw[gi]),
                .pulse     (btn_evt[gi])
            );
        end
    endgenerate

    assign enq_evt = btn_evt[0];
    assign deq_evt = btn_evt[1];

    assign full  = (len_in >= DEPTH_L);
    assign empty = (len_in == 8'd0);

    ctrl_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic              load_data;
    logic [DATA_W-1:0] data_to_q_reg;
    logic [DATA_W-1:0] shown_data_reg;
    logic              shown_valid_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        load_data  = 1'b0;
        case (state_reg)
            IDLE: begin
                // a legal dequeue takes priority; any losing press is reported
                if (deq_evt && !empty) begin
                    state_next = DEQ;
                    err_next   = enq_evt;
                end else begin
                    err_next = deq_evt;
                    if (enq_evt) begin
                        if (!full) begin
                            state_next = ENQ;
                            load_data  = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
            end
            ENQ:      state_next = ENQ_WAIT;
            ENQ_WAIT: state_next = IDLE;
            DEQ: begin
                state_next = DEQ_WAIT;
                cnt_next   = CNT_LOAD;
            end
            // counts DEQ_LAT-1 down to 0, so the wait spans DEQ_LAT cycles
            DEQ_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            CAPTURE:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (state_reg != IDLE && (enq_evt || deq_evt)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            err_reg         <= 1'b0;
            data_to_q_reg   <= '0;
            shown_data_reg  <= '0;
            shown_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            if (load_data) begin
                data_to_q_reg <= sw_data;
            end
            if (state_reg == CAPTURE) begin
                shown_data_reg  <= data_q_in;
                shown_valid_reg <= 1'b1;
            end
        end
    end

    assign enqueue_out = (state_reg == ENQ);
    assign dequeue_out = (state_reg == DEQ);
    assign err_out     = err_reg;
    assign data_to_q   = data_to_q_reg;
    assign shown_data  = shown_data_reg;
    assign shown_valid = shown_valid_reg;

`ifdef CTRL_FILA_STATS_EN
    logic [7:0] enq_count_reg, deq_count_reg, rej_count_reg;

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            enq_count_reg <= '0;
            deq_count_reg <= '0;
            rej_count_reg <= '0;
        end else begin
            if (enqueue_out && enq_count_reg != 8'hFF) enq_count_reg <= enq_count_reg + 8'd1;
            if (dequeue_out && deq_count_reg != 8'hFF) deq_count_reg <= deq_count_reg + 8'd1;
            if (err_out && rej_count_reg != 8'hFF)     rej_count_reg <= rej_count_reg + 8'd1;
        end
    end

    assign enq_count = enq_count_reg;
    assign deq_count = deq_count_reg;
    assign rej_count = rej_count_reg;
`endif

endmodule

// File: tb/tb_ctrl_fila.sv
// Scoreboard bench for ctrl_fila: the bench plays the queue, predicts every
// strobe / reject / captured byte from a byte-queue model, and a monitor checks them.
`timescale 1us/1ns
module tb_ctrl_fila;

    localparam int DEPTH = 8;

    logic       clk_10KHz = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_enq   = 1'b0;
    logic       btn_deq   = 1'b0;
    logic [7:0] sw_data   = 8'h00;
    logic [7:0] len_in    = 8'd8;
    logic [7:0] data_q_in = 8'h00;
    logic       enqueue_out, dequeue_out, shown_valid, full, empty, err_out;
    logic [7:0] data_to_q, shown_data;
`ifdef CTRL_FILA_STATS_EN
    logic [7:0] enq_count, deq_count, rej_count;
`endif

    ctrl_fila dut (
        .clk_10KHz   (clk_10KHz),
        .reset       (reset),
        .btn_enq     (btn_enq),
        .btn_deq     (btn_deq),
        .sw_data     (sw_data),
        .len_in      (len_in),
        .data_q_in   (data_q_in),
        .enqueue_out (enqueue_out),
        .dequeue_out (dequeue_out),
        .data_to_q   (data_to_q),
        .shown_data  (shown_data),
        .shown_valid (shown_valid),
        .full        (full),
        .empty       (empty),
        .err_out     (err_out)
`ifdef CTRL_FILA_STATS_EN
        ,
        .enq_count   (enq_count),
        .deq_count   (deq_count),
        .rej_count   (rej_count)
`endif
    );

    always #50 clk_10KHz = ~clk_10KHz;

    int cyc = 0;
    always @(posedge clk_10KHz) cyc <= cyc + 1;

    typedef enum int {K_ENQ = 1, K_DEQ = 2, K_ERR = 3} kind_t;
    typedef struct { kind_t kind; int cyc; logic [7:0] data; } exp_t;
    typedef struct { int cyc; logic valid; logic [7:0] data; } shw_t;

    exp_t       exp_q[$];
    shw_t       shw_q[$];
    logic [7:0] fifo[$];
    int checks = 0;
    int errors = 0;
    int n_enq = 0, n_deq = 0, n_rej = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_10KHz);
        #1;
    endtask

    task automatic push_exp(input kind_t k, input int c, input logic [7:0] d);
        exp_t e;
        e.kind = k; e.cyc = c; e.data = d;
        exp_q.push_back(e);
        if (k == K_ENQ) n_enq++;
        if (k == K_DEQ) n_deq++;
        if (k == K_ERR) n_rej++;
    endtask

    task automatic push_shw(input int c, input logic v, input logic [7:0] d);
        shw_t s;
        s.cyc = c; s.valid = v; s.data = d;
        shw_q.push_back(s);
    endtask

    // Called right after edge n. Decision edge is n+4 (2 sync flops, edge
    // register, FSM), captured byte visible after n+8 (DEQ, DEQ_LAT waits, CAPTURE).
    task automatic press(input bit e, input bit d, input logic [7:0] swv, input int hold,
                         input bit late_enq, input bit rst_mid, input bit keep);
        int n;
        bit deq_ok, enq_ok;
        logic [7:0] head;
        n      = cyc;
        deq_ok = d && (fifo.size() > 0);
        enq_ok = e && !deq_ok && (fifo.size() < DEPTH);
        head   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        btn_enq   = e;
        btn_deq   = d;
        sw_data   = swv;
        data_q_in = ~head;
        if (deq_ok) push_exp(K_DEQ, n + 4, 8'h00);
        if (enq_ok) push_exp(K_ENQ, n + 4, swv);
        if ((d && !deq_ok) || (e && !enq_ok)) push_exp(K_ERR, n + 4, 8'h00);
        if (late_enq) push_exp(K_ERR, n + 6, 8'h00);
        if (deq_ok && !rst_mid) push_shw(n + 8, 1'b1, head);
        if (rst_mid) push_shw(n + 6, 1'b0, 8'h00);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == hold) begin
                btn_enq = 1'b0;
                btn_deq = 1'b0;
            end
            if (late_enq && k == 2) btn_enq = 1'b1;
            if (late_enq && k == 4) btn_enq = 1'b0;
            if (k == 4) sw_data = 8'($urandom);
            if (k == 5) begin
                if (enq_ok && keep) fifo.push_back(swv);
                if (deq_ok) data_q_in = head;
                if (rst_mid) reset = 1'b1;
            end
            if (k == 6) begin
                if (rst_mid) begin
                    reset = 1'b0;
                    fifo.delete();
                    n_enq = 0; n_deq = 0; n_rej = 0;
                end else if (deq_ok) begin
                    void'(fifo.pop_front());
                end
            end
            len_in = 8'(fifo.size());
        end
    endtask

    task automatic mon_evt(input kind_t k, input logic [7:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(k), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            if (k == K_ENQ) chk("data_to_q", 32'(d), 32'(e.data));
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic [7:0] ref_shown = 8'h00;
    logic       ref_valid = 1'b0;
    logic       prev_strobe = 1'b0;
    initial begin
        forever begin
            @(negedge clk_10KHz);
            while (shw_q.size() > 0 && shw_q[0].cyc <= cyc) begin
                ref_shown = shw_q[0].data;
                ref_valid = shw_q[0].valid;
                void'(shw_q.pop_front());
            end
            chk("full", 32'(full), 32'(len_in >= 8'(DEPTH)));
            chk("empty", 32'(empty), 32'(len_in == 8'd0));
            chk("shown_valid", 32'(shown_valid), 32'(ref_valid));
            chk("shown_data", 32'(shown_data), 32'(ref_shown));
            if (enqueue_out || dequeue_out) begin
                chk("strobe_overlap", 32'(enqueue_out & dequeue_out), 32'd0);
                chk("strobe_back_to_back", 32'(prev_strobe), 32'd0);
            end
            prev_strobe = enqueue_out | dequeue_out;
            if (enqueue_out) mon_evt(K_ENQ, data_to_q);
            if (dequeue_out) mon_evt(K_DEQ, 8'h00);
            if (err_out)     mon_evt(K_ERR, 8'h00);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missing_event", 32'(exp_q[0].kind), 32'd0);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // reset state, with a full queue reported so full/empty are exercised
        repeat (3) step();
        chk("rst_enqueue_out", 32'(enqueue_out), 32'd0);
        chk("rst_dequeue_out", 32'(dequeue_out), 32'd0);
        chk("rst_err_out", 32'(err_out), 32'd0);
        chk("rst_data_to_q", 32'(data_to_q), 32'd0);
        chk("rst_full", 32'(full), 32'd1);
        chk("rst_empty", 32'(empty), 32'd0);
        len_in = 8'd0;
        reset  = 1'b0;
        step();

        press(1, 0, 8'h3C, 5, 0, 0, 1);                      // held button: one enqueue
        for (int i = 0; i < 7; i++) press(1, 0, 8'($urandom), $urandom_range(1, 5), 0, 0, 1);
        press(1, 0, 8'h77, 3, 0, 0, 1);                      // full: rejected
        press(0, 1, 8'h00, 2, 0, 0, 1);                      // dequeue shows 8'h3C
        press(1, 1, 8'h11, 4, 0, 0, 1);                      // both: dequeue wins
        press(0, 1, 8'h00, 1, 1, 0, 1);                      // enq during DEQ_WAIT dropped
        for (int i = 0; i < 8; i++) press(0, 1, 8'h00, $urandom_range(1, 5), 0, 0, 1);
        press(1, 1, 8'hA5, 2, 0, 0, 1);                      // empty: enq proceeds, deq rejected
        for (int i = 0; i < 40; i++)
            press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  $urandom_range(1, 5), 0, 0, 1);
`ifdef CTRL_FILA_STATS_EN
        chk("enq_count", 32'(enq_count), 32'((n_enq > 255) ? 255 : n_enq));
        chk("deq_count", 32'(deq_count), 32'((n_deq > 255) ? 255 : n_deq));
        chk("rej_count", 32'(rej_count), 32'((n_rej > 255) ? 255 : n_rej));
`endif
        if (fifo.size() == 0) press(1, 0, 8'h5A, 2, 0, 0, 1);
        press(0, 1, 8'h00, 2, 0, 1, 1);                      // reset right after dequeue strobe
        press(1, 0, 8'hC3, 2, 0, 0, 1);                      // FSM idle again after reset
`ifdef CTRL_FILA_STATS_EN
        for (int i = 0; i < 300; i++) press(1, 0, 8'($urandom), 2, 0, 0, 0);
        chk("enq_count_sat", 32'(enq_count), 32'((n_enq > 255) ? 255 : n_enq));
        chk("deq_count_post", 32'(deq_count), 32'(n_deq));
        chk("rej_count_post", 32'(rej_count), 32'(n_rej));
`endif
        repeat (4) step();
        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
